// File: rtl/nf10_sram_fifo_pkg.sv
// Shared definitions for the SRAM FIFO packer and the fifo_to_axi unpacker:
// packed-word field offsets, packed-word width and the sequence enumeration.
package nf10_sram_fifo_pkg;

    localparam int FIFO_WIDTH = 201;
    localparam int DATA_W     = 192;

    localparam int DATA_HI  = 200;
    localparam int DATA_LO  = 9;
    localparam int CNT_HI   = 8;
    localparam int CNT_LO   = 4;
    localparam int SEQ_HI   = 3;
    localparam int SEQ_LO   = 2;
    localparam int LAST_BIT = 1;
    localparam int REAL_BIT = 0;

    // Position of a 192-bit word inside a 3-beat / 4-word group.
    typedef enum logic [1:0] {
        SEQ0 = 2'd0,
        SEQ1 = 2'd1,
        SEQ2 = 2'd2,
        SEQ3 = 2'd3
    } seq_e;

endpackage

// File: rtl/fifo_to_axi_outreg.sv
// One-entry AXI4-Stream output register. A load replaces the held beat; the
// parent only loads when the slot is empty or being drained this cycle.
module fifo_to_axi_outreg #(
    parameter int TDATA_WIDTH = 32,
    parameter int TUSER_WIDTH = 128
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic [8*TDATA_WIDTH-1:0]   ld_data,
    input  logic [TDATA_WIDTH-1:0]     ld_strb,
    input  logic                       ld_last,
    input  logic [TUSER_WIDTH-1:0]     ld_user,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [8*TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [TDATA_WIDTH-1:0]     m_axis_tstrb,
    output logic                       m_axis_tlast,
    output logic [TUSER_WIDTH-1:0]     m_axis_tuser
);

    logic                     valid_q, valid_d;
    logic [8*TDATA_WIDTH-1:0] data_q, data_d;
    logic [TDATA_WIDTH-1:0]   strb_q, strb_d;
    logic                     last_q, last_d;
    logic [TUSER_WIDTH-1:0]   user_q, user_d;

    // Next-state: load wins over drain; payload holds until replaced.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        strb_d  = strb_q;
        last_d  = last_q;
        user_d  = user_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = ld_data;
            strb_d  = ld_strb;
            last_d  = ld_last;
            user_d  = ld_user;
        end else if (m_axis_tready) begin
            valid_d = 1'b0;
        end
    end

    // Register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            strb_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            last_q  <= last_d;
            user_q  <= user_d;
        end
    end

    assign m_axis_tvalid = valid_q;
    assign m_axis_tdata  = data_q;
    assign m_axis_tstrb  = strb_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tuser  = user_q;

endmodule

// File: rtl/fifo_to_axi.sv
// Reassembles 256-bit AXI4-Stream beats from 192-bit packed FIFO words
// (4 words -> 3 beats). Optional sequence checking is enabled by defining
// SRAM_FIFO_SEQ_CHECK_EN; otherwise the seq field is ignored.
module fifo_to_axi
    import nf10_sram_fifo_pkg::*;
#(
    parameter int TDATA_WIDTH = 32,
    parameter int TUSER_WIDTH = 128,
    parameter int FIFO_WIDTH  = nf10_sram_fifo_pkg::FIFO_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [FIFO_WIDTH-1:0]    in_data,
    input  logic                     in_empty,
    input  logic [TUSER_WIDTH-1:0]   in_tuser,
    output logic                     in_rd_en,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [8*TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [TDATA_WIDTH-1:0]   m_axis_tstrb,
    output logic [TDATA_WIDTH-1:0]   m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic [TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic [31:0]              out_beat_cnt,
    output logic [15:0]              seq_err_cnt
);

    seq_e                     expected_q, expected_d;
    logic [DATA_W-1:0]        residual_q, residual_d;
    logic                     last_pending_q, last_pending_d;
    logic [31:0]              out_beat_cnt_q, out_beat_cnt_d;

    logic [DATA_W-1:0]        word_data;
    logic [4:0]               word_cnt;
    seq_e                     word_seq;
    logic                     word_last;
    logic                     word_real;
    logic                     seq_match;
    logic                     produces_beat;
    logic                     beat_load;
    logic [8*TDATA_WIDTH-1:0] beat_data;
    logic [TDATA_WIDTH-1:0]   beat_strb;

    assign word_data = in_data[DATA_HI:DATA_LO];
    assign word_cnt  = in_data[CNT_HI:CNT_LO];
    assign word_seq  = seq_e'(in_data[SEQ_HI:SEQ_LO]);
    assign word_last = in_data[LAST_BIT];
    assign word_real = in_data[REAL_BIT];

`ifdef SRAM_FIFO_SEQ_CHECK_EN
    assign seq_match = (word_seq == expected_q);
`else
    assign seq_match = 1'b1;
`endif

    // A word that only fills the residual may pop even while the output is full.
    assign produces_beat = seq_match && (expected_q != SEQ0);
    assign in_rd_en      = reset && !in_empty &&
                           (!produces_beat || !m_axis_tvalid || m_axis_tready);

    // Byte enables: low N bytes, count 0 meaning a full beat.
    always_comb begin
        beat_strb = '0;
        for (int unsigned i = 0; i < TDATA_WIDTH; i++) begin
            beat_strb[i] = (word_cnt == 5'd0) || (i < {27'd0, word_cnt});
        end
    end

    // Reassembly state machine driven by the expected sequence position.
    always_comb begin
        expected_d     = expected_q;
        residual_d     = residual_q;
        last_pending_d = last_pending_q;
        beat_load      = 1'b0;
        beat_data      = '0;
        if (in_rd_en) begin
            if (!seq_match) begin
                // Out-of-order word: drop partial state, resync on a seq0 word.
                residual_d     = '0;
                last_pending_d = 1'b0;
                if (word_seq == SEQ0) begin
                    residual_d     = word_data;
                    last_pending_d = word_last;
                    expected_d     = SEQ1;
                end else begin
                    expected_d = SEQ0;
                end
            end else begin
                case (expected_q)
                    SEQ0: begin
                        residual_d     = word_data;
                        last_pending_d = word_last;
                        expected_d     = SEQ1;
                    end
                    SEQ1: begin
                        beat_load      = 1'b1;
                        beat_data      = {word_data[63:0], residual_q};
                        last_pending_d = word_last;
                        if (word_real) begin
                            residual_d = {128'd0, word_data[191:64]};
                            expected_d = SEQ2;
                        end else begin
                            residual_d = '0;
                            expected_d = SEQ0;
                        end
                    end
                    SEQ2: begin
                        beat_load      = 1'b1;
                        beat_data      = {word_data[127:0], residual_q[127:0]};
                        last_pending_d = word_last;
                        if (word_real) begin
                            residual_d = {128'd0, word_data[191:128]};
                            expected_d = SEQ3;
                        end else begin
                            residual_d = '0;
                            expected_d = SEQ0;
                        end
                    end
                    default: begin
                        beat_load  = 1'b1;
                        beat_data  = {word_data, residual_q[63:0]};
                        expected_d = SEQ0;
                    end
                endcase
            end
        end
    end

    // Downstream beat counter, free-running wrap.
    always_comb begin
        out_beat_cnt_d = out_beat_cnt_q;
        if (m_axis_tvalid && m_axis_tready) begin
            out_beat_cnt_d = out_beat_cnt_q + 32'd1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            expected_q     <= SEQ0;
            residual_q     <= '0;
            last_pending_q <= 1'b0;
            out_beat_cnt_q <= '0;
        end else begin
            expected_q     <= expected_d;
            residual_q     <= residual_d;
            last_pending_q <= last_pending_d;
            out_beat_cnt_q <= out_beat_cnt_d;
        end
    end

    assign out_beat_cnt = out_beat_cnt_q;

`ifdef SRAM_FIFO_SEQ_CHECK_EN
    logic [15:0] seq_err_cnt_q, seq_err_cnt_d;

    // Saturating count of out-of-order words.
    always_comb begin
        seq_err_cnt_d = seq_err_cnt_q;
        if (in_rd_en && !seq_match && (seq_err_cnt_q != 16'hFFFF)) begin
            seq_err_cnt_d = seq_err_cnt_q + 16'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            seq_err_cnt_q <= '0;
        end else begin
            seq_err_cnt_q <= seq_err_cnt_d;
        end
    end

    assign seq_err_cnt = seq_err_cnt_q;
`else
    assign seq_err_cnt = '0;
`endif

    fifo_to_axi_outreg #(
        .TDATA_WIDTH (TDATA_WIDTH),
        .TUSER_WIDTH (TUSER_WIDTH)
    ) u_outreg (
        .clk           (clk),
        .reset         (reset),
        .load          (beat_load),
        .ld_data       (beat_data),
        .ld_strb       (beat_strb),
        .ld_last       (last_pending_q),
        .ld_user       (in_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
    );

    assign m_axis_tkeep = m_axis_tstrb;

endmodule

// File: tb/tb_fifo_to_axi.sv
// Self-checking bench for fifo_to_axi: a packer model splits random 256-bit
// beats into 192-bit words; a scoreboard checks the reassembled beats.
module tb_fifo_to_axi;

    logic         clk = 1'b0;
    logic         reset;
    logic [200:0] in_data;
    logic         in_empty;
    logic [127:0] in_tuser;
    logic         in_rd_en;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tstrb;
    logic [31:0]  m_axis_tkeep;
    logic         m_axis_tlast;
    logic [127:0] m_axis_tuser;
    logic [31:0]  out_beat_cnt;
    logic [15:0]  seq_err_cnt;

    always #5 clk = ~clk;

    fifo_to_axi #(
        .TDATA_WIDTH (32),
        .TUSER_WIDTH (128),
        .FIFO_WIDTH  (201)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_empty      (in_empty),
        .in_tuser      (in_tuser),
        .in_rd_en      (in_rd_en),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .out_beat_cnt  (out_beat_cnt),
        .seq_err_cnt   (seq_err_cnt)
    );

    typedef struct {
        logic [200:0] d;
        logic [127:0] u;
        logic         beat;
    } word_t;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  s;
        logic         l;
        logic [127:0] u;
        logic [4:0]   c;
    } beat_t;

    word_t       wq[$];
    beat_t       eq[$];
    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] beat_cnt_m = '0;
    int          tready_mode = 0;
    bit          gaps = 1'b0;
    bit          full_rate = 1'b0;
    bit          rst_drv = 1'b0;
    bit          rd_pending = 1'b0;
    bit          exp_valid_next = 1'b0;
    bit          prev_stall = 1'b0;
    logic [255:0] sv_data;
    logic [31:0]  sv_strb;
    logic         sv_last;
    logic [127:0] sv_user;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        logic [255:0] r;
        r = rnd256();
        return r[127:0];
    endfunction

    function automatic logic [200:0] mkword(input logic [191:0] d, input logic [4:0] c,
                                            input logic [1:0] s, input logic l, input logic r);
        return {d, c, s, l, r};
    endfunction

    // Packer model: packet of nbeats beats, count only on the final beat.
    task automatic push_packet(input int nbeats, input int last_cnt);
        beat_t bs[$];
        for (int j = 0; j < nbeats; j++) begin
            beat_t b;
            b.d = rnd256();
            b.c = (j == nbeats - 1) ? 5'(last_cnt) : 5'd0;
            b.s = (b.c == 5'd0) ? 32'hFFFF_FFFF : ((32'd1 << b.c) - 32'd1);
            b.l = (j == nbeats - 1);
            b.u = '0;
            bs.push_back(b);
        end
        for (int g = 0; g < nbeats; g += 3) begin
            int n;
            logic [767:0] all;
            n = (nbeats - g < 3) ? nbeats - g : 3;
            for (int k = 0; k < 3; k++) all[256*k +: 256] = rnd256();
            for (int k = 0; k < n; k++) all[256*k +: 256] = bs[g+k].d;
            for (int k = 0; k <= n; k++) begin
                word_t w;
                logic [4:0] c;
                logic l;
                c = (k >= 1) ? bs[g+k-1].c : 5'($urandom_range(0, 31));
                l = (k < n) ? bs[g+k].l : 1'b0;
                w.d = mkword(all[192*k +: 192], c, 2'(k), l, !(k == n && n < 3));
                w.u = rnd128();
                w.beat = (k >= 1);
                wq.push_back(w);
                if (k >= 1) begin
                    bs[g+k-1].u = w.u;
                    eq.push_back(bs[g+k-1]);
                end
            end
        end
    endtask

    // One clock: retire last pop, drive inputs at negedge, sample before posedge.
    task automatic tick();
        @(negedge clk);
        if (!reset) beat_cnt_m = '0;
        if (rd_pending && wq.size() > 0) wq.delete(0);
        if (prev_stall) begin
            chk("hold_tvalid", m_axis_tvalid, 1'b1);
            chk("hold_tdata", m_axis_tdata, sv_data);
            chk("hold_tstrb", m_axis_tstrb, sv_strb);
            chk("hold_tlast", m_axis_tlast, sv_last);
            chk("hold_tuser", m_axis_tuser, sv_user);
        end
        if (exp_valid_next) chk("latency_tvalid", m_axis_tvalid, 1'b1);
        reset = rst_drv;
        if (wq.size() > 0 && !(gaps && $urandom_range(0, 3) == 0)) begin
            in_empty = 1'b0;
            in_data  = wq[0].d;
            in_tuser = wq[0].u;
        end else begin
            in_empty = 1'b1;
            in_data  = '0;
            in_tuser = '0;
        end
        case (tready_mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = ($urandom_range(0, 2) != 0);
            default: m_axis_tready = 1'b0;
        endcase
        #1;
        rd_pending     = in_rd_en;
        exp_valid_next = in_rd_en && !in_empty && wq.size() > 0 && wq[0].beat;
        if (full_rate && !in_empty) chk("full_rate_rd_en", in_rd_en, 1'b1);
        chk("out_beat_cnt", out_beat_cnt, beat_cnt_m);
        if (m_axis_tvalid && m_axis_tready) begin
            if (eq.size() == 0) begin
                chk("unexpected_beat", 0, 1);
            end else begin
                beat_t b;
                b = eq.pop_front();
                chk("tdata", m_axis_tdata, b.d);
                chk("tstrb", m_axis_tstrb, b.s);
                chk("tkeep", m_axis_tkeep, b.s);
                chk("tlast", m_axis_tlast, b.l);
                chk("tuser", m_axis_tuser, b.u);
            end
            beat_cnt_m = beat_cnt_m + 32'd1;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready && rst_drv;
        sv_data = m_axis_tdata;
        sv_strb = m_axis_tstrb;
        sv_last = m_axis_tlast;
        sv_user = m_axis_tuser;
    endtask

    task automatic drain(input string tag);
        int i = 0;
        while ((wq.size() != 0 || eq.size() != 0) && i < 2000) begin
            tick();
            i++;
        end
        chk({tag, "_drain_in_time"}, (i < 2000), 1'b1);
        tick();
        tick();
        chk({tag, "_idle_tvalid"}, m_axis_tvalid, 1'b0);
    endtask

    initial begin
        reset         = 1'b0;
        in_data       = '0;
        in_empty      = 1'b1;
        in_tuser      = '0;
        m_axis_tready = 1'b0;
        rst_drv       = 1'b0;
        tready_mode   = 2;

        // Reset state, with a word waiting that must not be popped.
        repeat (3) tick();
        wq.push_back('{d: mkword(192'd1, 5'd0, 2'd0, 1'b0, 1'b1), u: '0, beat: 1'b0});
        tick();
        chk("rst_rd_en", in_rd_en, 1'b0);
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tdata", m_axis_tdata, '0);
        chk("rst_tstrb", m_axis_tstrb, '0);
        chk("rst_tkeep", m_axis_tkeep, '0);
        chk("rst_tlast", m_axis_tlast, 1'b0);
        chk("rst_tuser", m_axis_tuser, '0);
        chk("rst_beat_cnt", out_beat_cnt, '0);
        chk("rst_seq_err", seq_err_cnt, '0);
        wq.delete();
        rst_drv     = 1'b1;
        tready_mode = 0;
        tick();

        // Three full beats, last on the third, at full rate.
        full_rate = 1'b1;
        push_packet(3, 0);
        drain("three_full");

        // Single short beat closed by a flush, then a normal packet.
        push_packet(1, 5);
        push_packet(3, 0);
        drain("short_flush");
        full_rate = 1'b0;

        // Mid-stream backpressure for 10 cycles.
        push_packet(12, 9);
        repeat (3) tick();
        chk("stall_start_tvalid", m_axis_tvalid, 1'b1);
        tready_mode = 2;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 3) chk("stall_rd_en", in_rd_en, 1'b0);
        end
        tready_mode = 0;
        drain("stall");

        // Random packets, random backpressure and FIFO gaps.
        gaps        = 1'b1;
        tready_mode = 1;
        for (int p = 0; p < 20; p++) push_packet($urandom_range(1, 7), $urandom_range(0, 31));
        drain("random");
        gaps        = 1'b0;
        tready_mode = 0;

`ifdef SRAM_FIFO_SEQ_CHECK_EN
        // seq2 injected where seq1 is expected, then a clean packet.
        wq.push_back('{d: mkword(rnd256(), 5'd0, 2'd0, 1'b0, 1'b1), u: rnd128(), beat: 1'b0});
        wq.push_back('{d: mkword(rnd256(), 5'd0, 2'd2, 1'b0, 1'b1), u: rnd128(), beat: 1'b0});
        push_packet(3, 0);
        drain("seq_err");
        chk("seq_err_cnt", seq_err_cnt, 16'd1);
`else
        chk("seq_err_tied", seq_err_cnt, 16'd0);
`endif

        // Reset after a seq1 pop with the beat held in the output register.
        tready_mode = 2;
        push_packet(3, 0);
        begin
            int w = 0;
            while (m_axis_tvalid !== 1'b1 && w < 20) begin
                tick();
                w++;
            end
        end
        chk("pre_rst_tvalid", m_axis_tvalid, 1'b1);
        rst_drv = 1'b0;
        eq.delete();
        tick();
        chk("mid_rst_rd_en", in_rd_en, 1'b0);
        tick();
        chk("post_rst_tvalid", m_axis_tvalid, 1'b0);
        chk("post_rst_tdata", m_axis_tdata, '0);
        chk("post_rst_beat_cnt", out_beat_cnt, '0);
        chk("post_rst_seq_err", seq_err_cnt, '0);
        wq.delete();
        rst_drv     = 1'b1;
        tready_mode = 0;
        tick();
        full_rate = 1'b1;
        push_packet(2, 7);
        drain("after_reset");
        full_rate = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
